// File: rtl/fir_result_serializer.sv
// fir_result_serializer
//
// Output stage of the 4-lane FIR filter. Each result block (LANES
// accumulators of ACC_WIDTH bits) is captured on the filter's done pulse
// into a two-slot ring buffer. Each accumulator is then scaled back to an
// OUT_WIDTH-bit sample: round to nearest, arithmetic shift right by SHIFT,
// and then either saturate or wrap. Samples are streamed out one per
// valid/ready handshake, lane 0 first.
//
// Optional feature macro: FIR_RESULT_SATURATE_EN
//   defined     -> scaled samples are clamped to the signed OUT_WIDTH range
//   not defined -> scaled samples wrap (low OUT_WIDTH bits are kept)
//
// Ports
//   clkIn        sole clock, rising edge
//   resetIn      synchronous, active-high reset
//   doneIn       filter done pulse; dataIn is valid in this cycle
//   dataIn       result block; lane 0 in the MSB slice, lane LANES-1 in the LSB slice
//   readyIn      sink ready
//   clearIn      clears overflowOut and dropCountOut
//   validOut     dataOut/laneOut/lastOut are valid
//   dataOut      scaled signed sample
//   laneOut      lane index of dataOut
//   lastOut      high together with lane LANES-1
//   fullOut      both block slots are occupied (combinational from occupancy)
//   overflowOut  sticky flag: at least one block was dropped
//   dropCountOut number of dropped blocks, saturating at 255

module fir_result_serializer #(
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15
) (
  input  logic                         clkIn,
  input  logic                         resetIn,
  input  logic                         doneIn,
  input  logic [ACC_WIDTH*LANES-1:0]   dataIn,
  input  logic                         readyIn,
  input  logic                         clearIn,
  output logic                         validOut,
  output logic [OUT_WIDTH-1:0]         dataOut,
  output logic [$clog2(LANES)-1:0]     laneOut,
  output logic                         lastOut,
  output logic                         fullOut,
  output logic                         overflowOut,
  output logic [7:0]                   dropCountOut
);

  localparam int LANE_W   = $clog2(LANES);
  localparam int BLOCK_W  = ACC_WIDTH * LANES;
  localparam int ROUND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Half an output LSB, added before the shift to round to nearest.
  localparam logic signed [ACC_WIDTH:0] ROUND_BIAS =
    (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << ROUND_SH) : '0;

  logic [BLOCK_W-1:0]          slotMem [2];
  logic                        wrPtr;
  logic                        rdPtr;
  logic [1:0]                  count;
  logic [LANE_W-1:0]           laneIdx;

  logic [BLOCK_W-1:0]          headBlock;
  logic [ACC_WIDTH-1:0]        headAcc;
  logic signed [ACC_WIDTH:0]   rounded;
  logic [OUT_WIDTH-1:0]        scaled;

  logic                        loadOut;
  logic                        freeSlot;
  logic                        capture;
  logic                        drop;

  // Lane 0 sits in the MSB slice, so the slice base walks downwards.
  assign headBlock = slotMem[rdPtr];
  assign headAcc   = headBlock[BLOCK_W-1 - ACC_WIDTH*int'(laneIdx) -: ACC_WIDTH];

  // One extra bit of headroom makes the rounding add overflow-free.
  assign rounded = $signed({headAcc[ACC_WIDTH-1], headAcc}) + ROUND_BIAS;

`ifdef FIR_RESULT_SATURATE_EN
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    $signed({{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    $signed({{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  logic signed [ACC_WIDTH:0] shifted;

  // Clamp the shifted value into the signed output range.
  always_comb begin
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_MAX) begin
      scaled = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      scaled = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      scaled = shifted[OUT_WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap: keep only the low OUT_WIDTH bits.
  assign scaled = OUT_WIDTH'(rounded >>> SHIFT);
`endif

  // The output register accepts a new sample when empty or being drained.
  // Loading the last lane of the head block frees its slot on that same
  // edge, which lets a coincident done pulse land in a "full" buffer.
  assign loadOut  = (!validOut || readyIn) && (count != 2'd0);
  assign freeSlot = loadOut && (laneIdx == LAST_LANE);
  assign capture  = doneIn && ((count != 2'd2) || freeSlot);
  assign drop     = doneIn && !capture;
  assign fullOut  = (count == 2'd2);

  // Block storage carries no reset; occupancy is tracked by count/ptrs.
  always_ff @(posedge clkIn) begin
    if (capture) begin
      slotMem[wrPtr] <= dataIn;
    end
  end

  // Ring pointers, occupancy and the lane walk through the head block.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      count   <= 2'd0;
      laneIdx <= '0;
    end else begin
      if (capture) begin
        wrPtr <= ~wrPtr;
      end
      if (freeSlot) begin
        rdPtr <= ~rdPtr;
      end
      if (loadOut) begin
        laneIdx <= (laneIdx == LAST_LANE) ? '0 : laneIdx + 1'b1;
      end
      case ({capture, freeSlot})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output register; holds its contents while the sink stalls.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      validOut <= 1'b0;
      dataOut  <= '0;
      laneOut  <= '0;
      lastOut  <= 1'b0;
    end else if (loadOut) begin
      validOut <= 1'b1;
      dataOut  <= scaled;
      laneOut  <= laneIdx;
      lastOut  <= (laneIdx == LAST_LANE);
    end else if (readyIn) begin
      validOut <= 1'b0;
    end
  end

  // Drop bookkeeping. A drop in the same cycle as clearIn wins, leaving
  // the counter at one rather than zero.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      overflowOut  <= 1'b0;
      dropCountOut <= 8'd0;
    end else if (drop) begin
      overflowOut <= 1'b1;
      if (clearIn) begin
        dropCountOut <= 8'd1;
      end else if (dropCountOut != 8'hFF) begin
        dropCountOut <= dropCountOut + 8'd1;
      end
    end else if (clearIn) begin
      overflowOut  <= 1'b0;
      dropCountOut <= 8'd0;
    end
  end

endmodule

// File: tb/tb_fir_result_serializer.sv
// tb_fir_result_serializer
//
// Directed bench for fir_result_serializer. Expected samples are pushed
// onto a scoreboard queue whenever a block that should be accepted is
// driven, and popped by a monitor at every valid/ready handshake.
// Respects FIR_RESULT_SATURATE_EN in its reference scaling.

module tb_fir_result_serializer;

  logic          clkIn = 1'b0;
  logic          resetIn;
  logic          doneIn;
  logic [127:0]  dataIn;
  logic          readyIn;
  logic          clearIn;
  logic          validOut;
  logic [15:0]   dataOut;
  logic [1:0]    laneOut;
  logic          lastOut;
  logic          fullOut;
  logic          overflowOut;
  logic [7:0]    dropCountOut;

  int            checks = 0;
  int            errors = 0;
  int            sampleCount = 0;
  logic [18:0]   expQ[$];

`ifdef FIR_RESULT_SATURATE_EN
  localparam logic [15:0] EXP_POS_BIG = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_BIG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_BIG = 16'h0000;
  localparam logic [15:0] EXP_NEG_BIG = 16'h0000;
`endif

  localparam logic [127:0] BLK_A = {32'h00004000, 32'h00003FFF, 32'hFFFF8000, 32'h00000000};
  localparam logic [127:0] BLK_S = {32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000};
  localparam logic [127:0] BLK_B = {32'h12345678, 32'hFFF00000, 32'h00010000, 32'h3FFFC000};
  localparam logic [127:0] BLK_C = {32'h00008000, 32'hFFFFC000, 32'h40000000, 32'hC0000000};

  fir_result_serializer dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .doneIn       (doneIn),
    .dataIn       (dataIn),
    .readyIn      (readyIn),
    .clearIn      (clearIn),
    .validOut     (validOut),
    .dataOut      (dataOut),
    .laneOut      (laneOut),
    .lastOut      (lastOut),
    .fullOut      (fullOut),
    .overflowOut  (overflowOut),
    .dropCountOut (dropCountOut)
  );

  always #5 clkIn = ~clkIn;

  // Reference scaling: round half up, arithmetic shift by 15, clamp or wrap.
  function automatic logic [15:0] scaleRef(input logic [31:0] acc);
    longint a;
    longint r;
    longint s;
    a = longint'($signed(acc));
    r = a + 64'sd16384;
    s = r >>> 15;
`ifdef FIR_RESULT_SATURATE_EN
    if (s > 64'sd32767) s = 64'sd32767;
    else if (s < -64'sd32768) s = -64'sd32768;
`endif
    return s[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  // Drive one done pulse; queue the expected samples if it should be kept.
  task automatic applyStimulus(input logic [127:0] blk, input bit accept);
    logic [31:0] acc;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        acc = blk[127 - 32*i -: 32];
        expQ.push_back({(i == 3), 2'(i), scaleRef(acc)});
      end
    end
    dataIn = blk;
    doneIn = 1'b1;
    tick();
    doneIn = 1'b0;
    dataIn = '0;
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    readyIn = 1'b1;
    while ((expQ.size() != 0 || validOut) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain_done", 32'(expQ.size() == 0 && !validOut), 32'd1);
  endtask

  // Scoreboard monitor: a handshake happens on the next rising edge.
  always @(negedge clkIn) begin
    logic [18:0] expSample;
    if (!resetIn && validOut && readyIn) begin
      sampleCount++;
      checkOutput("sb_not_empty", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        expSample = expQ.pop_front();
        checkOutput("sb_data", 32'(dataOut), 32'(expSample[15:0]));
        checkOutput("sb_lane", 32'(laneOut), 32'(expSample[17:16]));
        checkOutput("sb_last", 32'(lastOut), 32'(expSample[18]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int base;
    resetIn = 1'b1;
    doneIn  = 1'b0;
    dataIn  = '0;
    readyIn = 1'b0;
    clearIn = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", 32'(validOut), 32'd0);
    checkOutput("rst_data", 32'(dataOut), 32'd0);
    checkOutput("rst_lane", 32'(laneOut), 32'd0);
    checkOutput("rst_last", 32'(lastOut), 32'd0);
    checkOutput("rst_full", 32'(fullOut), 32'd0);
    checkOutput("rst_ovf", 32'(overflowOut), 32'd0);
    checkOutput("rst_drops", 32'(dropCountOut), 32'd0);
    resetIn = 1'b0;
    tick();

    // Basic rounding and latency: lanes at N+1..N+4
    $display("[TB] basic block");
    readyIn = 1'b1;
    applyStimulus(BLK_A, 1'b1);
    checkOutput("t1_not_yet", 32'(validOut), 32'd0);
    tick();
    checkOutput("t1_v0", 32'(validOut), 32'd1);
    checkOutput("t1_d0", 32'(dataOut), 32'h0001);
    checkOutput("t1_l0", 32'(laneOut), 32'd0);
    checkOutput("t1_last0", 32'(lastOut), 32'd0);
    tick();
    checkOutput("t1_d1", 32'(dataOut), 32'h0000);
    checkOutput("t1_l1", 32'(laneOut), 32'd1);
    tick();
    checkOutput("t1_d2", 32'(dataOut), 32'hFFFF);
    checkOutput("t1_l2", 32'(laneOut), 32'd2);
    checkOutput("t1_last2", 32'(lastOut), 32'd0);
    tick();
    checkOutput("t1_d3", 32'(dataOut), 32'h0000);
    checkOutput("t1_l3", 32'(laneOut), 32'd3);
    checkOutput("t1_last3", 32'(lastOut), 32'd1);
    tick();
    checkOutput("t1_idle", 32'(validOut), 32'd0);
    drain(20);

    // Extreme accumulators: saturate or wrap
    $display("[TB] extreme values");
    applyStimulus(BLK_S, 1'b1);
    tick();
    checkOutput("t2_pos", 32'(dataOut), 32'(EXP_POS_BIG));
    tick();
    checkOutput("t2_neg", 32'(dataOut), 32'(EXP_NEG_BIG));
    drain(20);

    // Back-pressure: lane 0 held for 5 cycles
    $display("[TB] stall");
    readyIn = 1'b0;
    applyStimulus(BLK_B, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 32'(validOut), 32'd1);
      checkOutput("t3_hold_data", 32'(dataOut), 32'(scaleRef(BLK_B[127 -: 32])));
      checkOutput("t3_hold_lane", 32'(laneOut), 32'd0);
      tick();
    end
    readyIn = 1'b1;
    tick();
    checkOutput("t3_lane1", 32'(laneOut), 32'd1);
    tick();
    checkOutput("t3_lane2", 32'(laneOut), 32'd2);
    tick();
    checkOutput("t3_lane3", 32'(laneOut), 32'd3);
    drain(20);

    // Overflow: third block dropped while stalled
    $display("[TB] overflow");
    readyIn = 1'b0;
    applyStimulus(BLK_A, 1'b1);
    checkOutput("t4_full1", 32'(fullOut), 32'd0);
    applyStimulus(BLK_B, 1'b1);
    checkOutput("t4_full2", 32'(fullOut), 32'd1);
    applyStimulus(BLK_C, 1'b0);
    checkOutput("t4_ovf", 32'(overflowOut), 32'd1);
    checkOutput("t4_drops", 32'(dropCountOut), 32'd1);
    checkOutput("t4_full3", 32'(fullOut), 32'd1);
    base = sampleCount;
    drain(40);
    checkOutput("t4_samples", 32'(sampleCount - base), 32'd8);
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    checkOutput("t4_clr_ovf", 32'(overflowOut), 32'd0);
    checkOutput("t4_clr_drops", 32'(dropCountOut), 32'd0);

    // Done coincident with the head's last lane loading into a full buffer
    $display("[TB] coincident accept");
    readyIn = 1'b0;
    applyStimulus(BLK_A, 1'b1);
    applyStimulus(BLK_B, 1'b1);
    checkOutput("t5_full", 32'(fullOut), 32'd1);
    checkOutput("t5_lane0", 32'(laneOut), 32'd0);
    base = sampleCount;
    readyIn = 1'b1;
    tick();
    tick();
    applyStimulus(BLK_C, 1'b1);
    checkOutput("t5_still_full", 32'(fullOut), 32'd1);
    checkOutput("t5_drops", 32'(dropCountOut), 32'd0);
    checkOutput("t5_ovf", 32'(overflowOut), 32'd0);
    drain(60);
    checkOutput("t5_samples", 32'(sampleCount - base), 32'd12);

    // Reset mid-block
    $display("[TB] reset mid-block");
    applyStimulus(BLK_B, 1'b1);
    tick();
    tick();
    checkOutput("t6_lane1", 32'(laneOut), 32'd1);
    resetIn = 1'b1;
    expQ.delete();
    tick();
    checkOutput("t6_rst_valid", 32'(validOut), 32'd0);
    checkOutput("t6_rst_full", 32'(fullOut), 32'd0);
    checkOutput("t6_rst_lane", 32'(laneOut), 32'd0);
    resetIn = 1'b0;
    tick();
    applyStimulus(BLK_C, 1'b1);
    tick();
    checkOutput("t6_restart_valid", 32'(validOut), 32'd1);
    checkOutput("t6_restart_lane", 32'(laneOut), 32'd0);
    checkOutput("t6_restart_data", 32'(dataOut), 32'(scaleRef(BLK_C[127 -: 32])));
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_result_serializer.md
# fir_result_serializer

Downstream stage of the 4-lane FIR filter. Captures each 4×32-bit result block on the filter's done pulse into a 2-block buffer. Scales every accumulator back to a 16-bit sample (round, arithmetic shift, saturate) and streams samples out one per valid/ready handshake, lane 0 first. Exports a full flag so the controller can hold off the filter's next start.

## Interface
- LANES, 4, accumulators per result block (filter SAMPLES_NUM)
- ACC_WIDTH, 32, width of each accumulator in dataIn
- OUT_WIDTH, 16, output sample width
- SHIFT, 15, right-shift applied after rounding (Q15 coefficients); legal 0..ACC_WIDTH-1
- clkIn  in  1  sole clock, rising edge
- resetIn  in  1  synchronous, active-high reset
- doneIn  in  1  filter done pulse; dataIn valid this cycle
- dataIn  in  ACC_WIDTH*LANES  result block; lane 0 in the MSB slice [ACC_WIDTH*LANES-1 -: ACC_WIDTH], lane LANES-1 in the LSB slice
- readyIn  in  1  sink ready
- validOut  out  1  dataOut/laneOut/lastOut valid
- dataOut  out  OUT_WIDTH  scaled signed sample
- laneOut  out  $clog2(LANES)  lane index of dataOut
- lastOut  out  1  high with lane LANES-1
- fullOut  out  1  both block slots occupied (combinational from occupancy)
- overflowOut  out  1  sticky: a block was dropped
- dropCountOut  out  8  dropped blocks, saturates at 255
- clearIn  in  1  clears overflowOut and dropCountOut

## Operation
- Storage: 2 block slots (ring, write ptr, read ptr, count 0..2), plus one output register stage.
- Capture: doneIn with count<2 writes dataIn into the write slot. Write ptr and count advance.
- Drop: doneIn with count==2 and no slot freed this cycle discards the block. overflowOut<=1 and dropCountOut increments, saturating at 255.
- Emit: the output register loads when (!validOut || readyIn) and count>0. It loads the scaled value of head slot, lane index. Lane index advances 0..LANES-1. After lane LANES-1 loads, the head slot is freed (read ptr advances, count decrements).
- No output holds are lost: while validOut && !readyIn, dataOut/laneOut/lastOut are stable.
- Scaling per lane, acc signed ACC_WIDTH:
  - r = acc + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in ACC_WIDTH+1 bits, no overflow.
  - s = r >>> SHIFT.
  - Clamp/wrap to OUT_WIDTH per Configuration.
- Simultaneous events:
  - doneIn in the same cycle the last lane of a full buffer's head loads is accepted; count stays 2.
  - clearIn together with a drop leaves overflowOut=1 and dropCountOut=1 (the drop wins).
- Reset (any time, including mid-block): count, ptrs, lane index 0. validOut 0; dataOut, laneOut, lastOut 0. overflowOut 0; dropCountOut 0; fullOut 0. Partially emitted blocks are discarded.

## Timing
- doneIn at edge N into an empty block with output register empty: validOut=1, lane 0 at N+1.
- With readyIn held high: lanes 0..3 at N+1..N+4. A second block captured before then follows at N+5 with no bubble. Sustained throughput is 1 sample/cycle.
- fullOut reflects the count after the last edge. The upstream controller must not assert filter start while fullOut=1.
- A slot is freed on the same edge its last lane enters the output register, not when that lane handshakes.
- overflowOut and dropCountOut update on the edge following the dropped doneIn.

## Configuration
- FIR_RESULT_SATURATE_EN defined: s is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Not defined: dataOut = s[OUT_WIDTH-1:0], i.e. two's-complement wrap, with no clamp logic.

## Test plan
- Reset, then doneIn with lane accs 0x00004000, 0x00003FFF, 0xFFFF8000, 0x00000000, readyIn=1 -> dataOut 0x0001, 0x0000, 0xFFFF, 0x0000 on cycles N+1..N+4; laneOut 0..3; lastOut only on the 4th.
- Lane acc 0x7FFFFFFF and 0x80000000 -> with FIR_RESULT_SATURATE_EN: 0x7FFF, 0x8000. Without: 0x0000, 0x0000.
- readyIn=0 for 5 cycles after first valid -> lane 0 value held stable. Then readyIn=1 -> lanes 1..3 follow on consecutive cycles, nothing lost.
- readyIn=0, three doneIn pulses -> fullOut=1 after the second. Third is dropped: overflowOut=1, dropCountOut=1. Then readyIn=1 -> exactly 8 samples, blocks 1 and 2 in order. clearIn -> flags 0.
- Buffer full, readyIn=1, doneIn coincident with lane 3 of the head loading -> block accepted; dropCountOut stays 0; all 12 samples emitted in order.
- resetIn asserted while lane 1 is valid -> next cycle validOut=0, fullOut=0. New doneIn afterwards -> emission restarts at lane 0 of the new block.
